// File: rtl/telemetria_pkg.sv
// Shared constants and state encodings for the level-telemetry serial receiver.
// Character codes of the D0 D1 D2 '#' frame, parser states and byte receiver states.
package telemetria_pkg;

  localparam logic [7:0] HEXA_30 = 8'h30;
  localparam logic [7:0] HEXA_23 = 8'h23;

  typedef enum logic [2:0] {
    ESPERA_D0  = 3'd0,
    ESPERA_D1  = 3'd1,
    ESPERA_D2  = 3'd2,
    ESPERA_FIM = 3'd3,
    SINC       = 3'd4
  } estado_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_estado_t;

endpackage

// File: rtl/receptor_telemetria_serial_rx.sv
// rx_serial_8N1: 2-FF synchronizer plus 8N1 bit timing; byte_ok is a combinational
// 1-cycle pulse in the stop-bit sample cycle, with ok = sampled stop bit.
module rx_serial_8N1
  import telemetria_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       RX,
  output logic [7:0] dados,
  output logic       byte_ok,
  output logic       ok
);

  localparam logic [15:0] W_FIM_BIT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] W_MEIO_BIT = 16'(CLKS_PER_BIT / 2 - 1);

  rx_estado_t  r_estado, w_estado_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [2:0]  r_bit, w_bit_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_s1, r_s2, r_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1     <= 1'b1;
      r_s2     <= 1'b1;
      r_prev   <= 1'b1;
      r_estado <= RX_IDLE;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
    end else begin
      r_s1     <= RX;
      r_s2     <= r_s1;
      r_prev   <= r_s2;
      r_estado <= w_estado_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
    end
  end

  always_comb begin
    w_estado_nxt = r_estado;
    w_cnt_nxt    = r_cnt;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    byte_ok      = 1'b0;
    ok           = r_s2;
    dados        = r_shift;
    case (r_estado)
      RX_IDLE: begin
        if (r_prev && !r_s2) begin
          w_estado_nxt = RX_START;
          w_cnt_nxt    = '0;
        end
      end
      RX_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (r_cnt == W_MEIO_BIT) begin
          w_cnt_nxt    = '0;
          w_bit_nxt    = '0;
          w_estado_nxt = r_s2 ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (r_cnt == W_FIM_BIT) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_s2, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_estado_nxt = RX_STOP;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      RX_STOP: begin
        if (r_cnt == W_FIM_BIT) begin
          byte_ok      = 1'b1;
          w_cnt_nxt    = '0;
          w_estado_nxt = RX_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_estado_nxt = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/receptor_telemetria_serial.sv
// Decodes "D0 D1 D2 #" ASCII frames into a 12-bit distance and flags malformed frames.
// Optional TELEM_TIMEOUT_EN adds an inter-character gap timeout on partial frames.
module receptor_telemetria_serial
  import telemetria_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
`ifdef TELEM_TIMEOUT_EN
  , parameter int TIMEOUT_CLKS = 5000000
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        RX,
  output logic [11:0] distancia,
  output logic        pronto,
  output logic        erro,
  output logic [2:0]  db_estado
);

  logic [7:0]  w_dados;
  logic        w_byte_ok, w_ok;
  logic        w_dig, w_fim, w_timeout;
  estado_t     r_estado, w_estado_nxt;
  logic [3:0]  r_n0, r_n1, r_n2;
  logic [11:0] r_dist;
  logic        r_pronto, r_erro;
  logic        w_pronto_nxt, w_erro_nxt;
  logic        w_ld0, w_ld1, w_ld2, w_ld_dist;

  rx_serial_8N1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock   (clock),
    .reset   (reset),
    .RX      (RX),
    .dados   (w_dados),
    .byte_ok (w_byte_ok),
    .ok      (w_ok)
  );

  // A framing error makes the byte BAD regardless of its value.
  assign w_dig = w_ok && (w_dados[7:4] == HEXA_30[7:4]);
  assign w_fim = w_ok && (w_dados == HEXA_23);

`ifdef TELEM_TIMEOUT_EN
  logic [31:0] r_gap;
  logic        w_gap_ativo;

  assign w_gap_ativo = (r_estado == ESPERA_D1) || (r_estado == ESPERA_D2) ||
                       (r_estado == ESPERA_FIM);
  assign w_timeout   = w_gap_ativo && !w_byte_ok && (r_gap == 32'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                       r_gap <= '0;
    else if (!w_gap_ativo || w_byte_ok || w_timeout) r_gap <= '0;
    else                              r_gap <= r_gap + 32'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= ESPERA_D0;
      r_n0     <= '0;
      r_n1     <= '0;
      r_n2     <= '0;
      r_dist   <= '0;
      r_pronto <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      r_estado <= w_estado_nxt;
      r_pronto <= w_pronto_nxt;
      r_erro   <= w_erro_nxt;
      if (w_ld0)     r_n0   <= w_dados[3:0];
      if (w_ld1)     r_n1   <= w_dados[3:0];
      if (w_ld2)     r_n2   <= w_dados[3:0];
      if (w_ld_dist) r_dist <= {r_n0, r_n1, r_n2};
    end
  end

  always_comb begin
    w_estado_nxt = r_estado;
    w_pronto_nxt = 1'b0;
    w_erro_nxt   = 1'b0;
    w_ld0        = 1'b0;
    w_ld1        = 1'b0;
    w_ld2        = 1'b0;
    w_ld_dist    = 1'b0;
    if (w_byte_ok) begin
      case (r_estado)
        ESPERA_D0, ESPERA_D1, ESPERA_D2: begin
          if (w_dig) begin
            w_ld0 = (r_estado == ESPERA_D0);
            w_ld1 = (r_estado == ESPERA_D1);
            w_ld2 = (r_estado == ESPERA_D2);
            w_estado_nxt = (r_estado == ESPERA_D0) ? ESPERA_D1 :
                           (r_estado == ESPERA_D1) ? ESPERA_D2 : ESPERA_FIM;
          end else if (w_fim) begin
            // An early '#' still marks a frame boundary: realign immediately.
            w_erro_nxt   = 1'b1;
            w_estado_nxt = ESPERA_D0;
          end else begin
            w_erro_nxt   = 1'b1;
            w_estado_nxt = SINC;
          end
        end
        ESPERA_FIM: begin
          if (w_fim) begin
            w_pronto_nxt = 1'b1;
            w_ld_dist    = 1'b1;
            w_estado_nxt = ESPERA_D0;
          end else begin
            w_erro_nxt   = 1'b1;
            w_estado_nxt = SINC;
          end
        end
        SINC: begin
          if (w_fim) w_estado_nxt = ESPERA_D0;
        end
        default: w_estado_nxt = ESPERA_D0;
      endcase
    end else if (w_timeout) begin
      w_erro_nxt   = 1'b1;
      w_estado_nxt = ESPERA_D0;
    end
  end

  assign distancia = r_dist;
  assign pronto    = r_pronto;
  assign erro      = r_erro;
  assign db_estado = r_estado;

endmodule
